// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side types: the packet pushed into the instruction queue and the fetch FSM encoding.
package fetch_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
  } fetch_packet_t;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

endpackage

// File: rtl/fetch_stage.sv
// Fetch unit: one aligned SS-wide imem request in flight, packets pushed into the instruction queue
// in the response cycle (or later from hold_buf when the queue is full); back-end redirects win in every state.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          SS       = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  output logic [3:0]               imem_rmask,
  input  logic [32*SS-1:0]         imem_rdata,
  input  logic                     imem_resp,
  input  logic                     iq_full,
  output logic                     iq_push,
  output fetch_packet_t [SS-1:0]   iq_out,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc
);

  localparam int          OFF      = $clog2(4 * SS);
  localparam int          FSW      = (SS > 1) ? $clog2(SS) : 1;
  localparam logic [31:0] BLK_SIZE = 32'(4 * SS);

  fetch_state_t         state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [FSW-1:0]       first_slot_q, first_slot_d;
  logic [32*SS-1:0]     hold_buf_q, hold_buf_d;
  logic                 push;
  logic                 use_hold;
  logic [3:0]           rmask;
  logic [FSW-1:0]       redir_slot;
  logic [32*SS-1:0]     src_words;
  fetch_packet_t [SS-1:0] pkt;
  logic                 unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];

  if (SS > 1) begin : g_slot
    assign redir_slot = redirect_pc[OFF-1:2];
  end else begin : g_noslot
    assign redir_slot = '0;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    first_slot_d = first_slot_q;
    hold_buf_d   = hold_buf_q;
    push         = 1'b0;
    use_hold     = 1'b0;
    rmask        = 4'h0;

    case (state_q)
      ISSUE: begin
        rmask      = 4'hf;
        req_addr_d = fetch_pc_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (imem_resp) begin
          if (!iq_full) begin
            push         = 1'b1;
            fetch_pc_d   = fetch_pc_q + BLK_SIZE;
            first_slot_d = '0;
            state_d      = ISSUE;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        use_hold = 1'b1;
        if (!iq_full) begin
          push         = 1'b1;
          fetch_pc_d   = fetch_pc_q + BLK_SIZE;
          first_slot_d = '0;
          state_d      = ISSUE;
        end
      end
      DISCARD: begin
        if (imem_resp) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    // A redirect overrides everything; an in-flight request must still be drained via DISCARD.
    if (redirect_valid) begin
      push         = 1'b0;
      hold_buf_d   = hold_buf_q;
      fetch_pc_d   = redirect_pc & ~(BLK_SIZE - 32'd1);
      first_slot_d = redir_slot;
      case (state_q)
        ISSUE:   state_d = DISCARD;
        WAIT:    state_d = imem_resp ? ISSUE : DISCARD;
        HOLD:    state_d = ISSUE;
        DISCARD: state_d = imem_resp ? ISSUE : DISCARD;
        default: state_d = ISSUE;
      endcase
    end
  end

  assign src_words = use_hold ? hold_buf_q : imem_rdata;

  for (genvar i = 0; i < SS; i++) begin : g_pkt
    assign pkt[i] = '{
      valid:   (FSW'(i) >= first_slot_q),
      pc:      fetch_pc_q + 32'(4 * i),
      pc_next: fetch_pc_q + 32'(4 * i + 4),
      inst:    src_words[32*i +: 32]
    };
  end

  assign imem_addr  = (state_q == ISSUE) ? fetch_pc_q : req_addr_q;
  assign imem_rmask = rst ? 4'h0 : rmask;
  assign iq_push    = push & ~rst & ~iq_full;
  assign iq_out     = rst ? '0 : pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ISSUE;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      first_slot_q <= '0;
      hold_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      first_slot_q <= first_slot_d;
      hold_buf_q   <= hold_buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (SS=2): reset, push/hold paths, redirects, PC wrap, reset in HOLD.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [31:0]          imem_addr;
  logic [3:0]           imem_rmask;
  logic [63:0]          imem_rdata;
  logic                 imem_resp;
  logic                 iq_full;
  logic                 iq_push;
  fetch_packet_t [1:0]  iq_out;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage #(.SS(2), .RESET_PC(32'h1eceb000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .iq_full        (iq_full),
    .iq_push        (iq_push),
    .iq_out         (iq_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_rdata = 64'hdeadbeef_cafef00d; imem_resp = 1'b0;
    iq_full = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step(); #1;
    chk("rst_rmask", 32'(imem_rmask), 32'h0);
    chk("rst_push", 32'(iq_push), 32'h0);
    chk("rst_valid0", 32'(iq_out[0].valid), 32'h0);
    chk("rst_pc1", iq_out[1].pc, 32'h0);
    chk("rst_inst0", iq_out[0].inst, 32'h0);

    // First request after reset release
    step(); rst = 1'b0; imem_rdata = '0; #1;
    chk("issue0_addr", imem_addr, 32'h1eceb000);
    chk("issue0_rmask", 32'(imem_rmask), 32'hf);
    step(); #1;
    chk("wait0_rmask", 32'(imem_rmask), 32'h0);
    chk("wait0_addr", imem_addr, 32'h1eceb000);
    step(); imem_resp = 1'b1; imem_rdata = {32'h00208113, 32'h00100093}; #1;
    chk("resp0_push", 32'(iq_push), 32'h1);
    chk("resp0_valid0", 32'(iq_out[0].valid), 32'h1);
    chk("resp0_pc0", iq_out[0].pc, 32'h1eceb000);
    chk("resp0_pcn0", iq_out[0].pc_next, 32'h1eceb004);
    chk("resp0_inst0", iq_out[0].inst, 32'h00100093);
    chk("resp0_pc1", iq_out[1].pc, 32'h1eceb004);
    chk("resp0_inst1", iq_out[1].inst, 32'h00208113);
    step(); imem_resp = 1'b0; #1;
    chk("issue1_addr", imem_addr, 32'h1eceb008);
    chk("issue1_rmask", 32'(imem_rmask), 32'hf);

    // Queue full during response: hold for three cycles, then push held data
    step(); #1;
    step(); imem_resp = 1'b1; iq_full = 1'b1; imem_rdata = {32'h00418213, 32'h00310193}; #1;
    chk("full_resp_push", 32'(iq_push), 32'h0);
    step(); imem_resp = 1'b0; imem_rdata = 64'h11111111_22222222; #1;
    chk("hold1_push", 32'(iq_push), 32'h0);
    chk("hold1_rmask", 32'(imem_rmask), 32'h0);
    step(); #1;
    chk("hold2_push", 32'(iq_push), 32'h0);
    step(); iq_full = 1'b0; #1;
    chk("hold_rel_push", 32'(iq_push), 32'h1);
    chk("hold_rel_pc0", iq_out[0].pc, 32'h1eceb008);
    chk("hold_rel_inst0", iq_out[0].inst, 32'h00310193);
    chk("hold_rel_inst1", iq_out[1].inst, 32'h00418213);
    step(); #1;
    chk("issue2_addr", imem_addr, 32'h1eceb010);
    chk("issue2_rmask", 32'(imem_rmask), 32'hf);

    // Redirect while waiting: outstanding response dropped via DISCARD
    step(); redirect_valid = 1'b1; redirect_pc = 32'h1eceb014; #1;
    chk("redir_wait_push", 32'(iq_push), 32'h0);
    step(); redirect_valid = 1'b0; #1;
    chk("discard_addr", imem_addr, 32'h1eceb010);
    chk("discard_rmask", 32'(imem_rmask), 32'h0);
    step(); imem_resp = 1'b1; imem_rdata = 64'h33333333_44444444; #1;
    chk("discard_push", 32'(iq_push), 32'h0);
    step(); imem_resp = 1'b0; #1;
    chk("issue3_addr", imem_addr, 32'h1eceb010);
    chk("issue3_rmask", 32'(imem_rmask), 32'hf);
    step(); #1;
    step(); imem_resp = 1'b1; imem_rdata = {32'h00628313, 32'h00520293}; #1;
    chk("redir_pkt_push", 32'(iq_push), 32'h1);
    chk("redir_pkt_valid0", 32'(iq_out[0].valid), 32'h0);
    chk("redir_pkt_valid1", 32'(iq_out[1].valid), 32'h1);
    chk("redir_pkt_pc1", iq_out[1].pc, 32'h1eceb014);
    chk("redir_pkt_pcn1", iq_out[1].pc_next, 32'h1eceb018);
    chk("redir_pkt_inst1", iq_out[1].inst, 32'h00628313);
    step(); imem_resp = 1'b0; #1;
    chk("issue4_addr", imem_addr, 32'h1eceb018);

    // Redirect coinciding with the response: straight back to ISSUE
    step(); #1;
    step(); imem_resp = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000104; #1;
    chk("redir_resp_push", 32'(iq_push), 32'h0);
    step(); imem_resp = 1'b0; redirect_valid = 1'b0; #1;
    chk("redir_resp_addr", imem_addr, 32'h00000100);
    chk("redir_resp_rmask", 32'(imem_rmask), 32'hf);
    step(); #1;
    step(); imem_resp = 1'b1; imem_rdata = {32'h00000013, 32'h00000073}; #1;
    chk("blk100_valid0", 32'(iq_out[0].valid), 32'h0);
    chk("blk100_pc1", iq_out[1].pc, 32'h00000104);

    // Redirect in ISSUE to the top of the address space; PC wraps to zero
    step(); imem_resp = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hfffffff8; #1;
    chk("redir_issue_addr", imem_addr, 32'h00000108);
    chk("redir_issue_rmask", 32'(imem_rmask), 32'hf);
    step(); redirect_valid = 1'b0; #1;
    chk("disc2_rmask", 32'(imem_rmask), 32'h0);
    chk("disc2_addr", imem_addr, 32'h00000108);
    step(); imem_resp = 1'b1; #1;
    chk("disc2_push", 32'(iq_push), 32'h0);
    step(); imem_resp = 1'b0; #1;
    chk("wrap_issue_addr", imem_addr, 32'hfffffff8);
    step(); #1;
    step(); imem_resp = 1'b1; imem_rdata = {32'h00a00513, 32'h00b00593}; #1;
    chk("wrap_valid0", 32'(iq_out[0].valid), 32'h1);
    chk("wrap_pc1", iq_out[1].pc, 32'hfffffffc);
    chk("wrap_pcn1", iq_out[1].pc_next, 32'h00000000);
    step(); imem_resp = 1'b0; #1;
    chk("wrap_next_addr", imem_addr, 32'h00000000);

    // Reset asserted while holding a full-queue response
    step(); #1;
    step(); imem_resp = 1'b1; iq_full = 1'b1; #1;
    chk("hold3_push", 32'(iq_push), 32'h0);
    step(); imem_resp = 1'b0; rst = 1'b1; #1;
    step(); #1;
    chk("hold_rst_push", 32'(iq_push), 32'h0);
    chk("hold_rst_rmask", 32'(imem_rmask), 32'h0);
    step(); rst = 1'b0; iq_full = 1'b0; #1;
    chk("post_rst_addr", imem_addr, 32'h1eceb000);
    chk("post_rst_rmask", 32'(imem_rmask), 32'hf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
